// File: rtl/hex_scan_display_if.sv
// Bus bundle for hex_scan_display.
//   data_in        : hex value, nibble i -> digit i (digit 0 rightmost)
//   data_valid     : single-cycle capture strobe
//   blank          : level, forces all anodes off
//   update_pending : captured value not yet on the display
//   C[7:1]         : active-low segments g..a
//   AN             : active-low anodes, one per digit
// master = producer of data (testbench / host), slave = the display block.
interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    data_valid;
    logic                    blank;
    logic                    update_pending;
    logic [7:1]              C;
    logic [NUM_DIGITS-1:0]   AN;

    modport master (
        output data_in, data_valid, blank,
        input  update_pending, C, AN
    );

    modport slave (
        input  data_in, data_valid, blank,
        output update_pending, C, AN
    );
endinterface

// File: rtl/hex_scan_display.sv
// Multiplexed hex 7-segment driver with double-buffered (tear-free) update.
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : hex_scan_display_if slave (data_in, data_valid, blank in;
//                update_pending, C, AN out)
// A prescaler divides clk into digit slots of REFRESH_DIV cycles; the digit
// index walks 0..NUM_DIGITS-1. Captured data sits in a shadow register and
// is only promoted to the display register at frame end, so one frame never
// mixes two values. AN/C are registered from the current index/display.
module hex_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hex_scan_display_if.slave    bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][3:0] nib_t;

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    nib_t                  shadow_q, shadow_d;
    nib_t                  disp_q, disp_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            c_q, c_d;

    nib_t                  din;
    logic                  tick, frame_end;
    logic [NUM_DIGITS-1:0] lz;

    assign din = bus.data_in;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    // lz[i] set when nibbles i..top are all zero; digit 0 always shown.
    always_comb begin
        logic all0;
        lz   = '0;
        all0 = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all0  = all0 && (disp_q[i] == 4'h0);
            lz[i] = LZ_BLANK && all0;
        end
    end

    always_comb begin
        tick      = (pre_q == PRE_MAX);
        frame_end = tick && (idx_q == IDX_MAX);

        pre_d    = tick ? '0 : pre_q + PW'(1);
        idx_d    = idx_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;

        if (tick)
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);

        // A strobe in the frame-end cycle bypasses the shadow stage.
        if (frame_end) begin
            if (bus.data_valid) begin
                shadow_d = din;
                disp_d   = din;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
            end
        end else if (bus.data_valid) begin
            shadow_d = din;
            pend_d   = 1'b1;
        end

        if (bus.blank || lz[idx_q]) begin
            an_d = '1;
            c_d  = 7'h7F;
        end else begin
            an_d = ~(NUM_DIGITS'(1) << idx_q);
            c_d  = seg(disp_q[idx_q]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            an_q     <= '1;
            c_q      <= 7'h7F;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            c_q      <= c_d;
        end
    end

    assign bus.update_pending = pend_q;
    assign bus.C              = c_q;
    assign bus.AN             = an_q;
endmodule
